fb_port_arbiter: RTL and testbench

Owns the single-port image frame buffer (BSRAM) and sequences frame capture into it. It accepts the byte stream from esp_interface, tracks the write pointer and frame boundaries, and shares the one memory port with lcd_controller pixel reads. LCD reads have absolute priority because display timing cannot stall; the SPI writer is back-pressured instead. It sits in top between esp_interface, lcd_controller and the BSRAM instance, and replaces the ad-hoc buffer logic there.

---
 rtl/fb_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Frame buffer port arbiter: sequences frame capture into a single-port BSRAM
// while giving LCD pixel reads absolute priority over the byte writer.
module fb_port_arbiter #(
  parameter int IMAGE_SIZE = 76800,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    DONE      = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   IMAGE_LIMIT = (ADDR_WIDTH + 1)'(IMAGE_SIZE);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  wr_accept;
  logic                  wr_store;
  logic                  wr_drop;
  logic                  last_byte;
  logic                  rd_in_range;
  logic                  rd_stage1;
  logic                  rd_stage1_ok;
  logic                  rd_stage2_ok;

  // Reads own the port whenever requested, so the writer is simply told to wait.
  assign wr_ready    = !rd_req && !frame_start && (state == IDLE || state == RECEIVING);
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_store    = wr_accept && (state == RECEIVING);
  assign wr_drop     = wr_accept && (state == IDLE);
  assign last_byte   = (wr_ptr == LAST_ADDR);
  assign rd_in_range = ({1'b0, rd_addr} < IMAGE_LIMIT);

  assign frame_busy  = (state == RECEIVING);
  assign frame_done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state  <= RECEIVING;
            wr_ptr <= '0;
          end
        end
        RECEIVING: begin
          if (frame_start) begin
            wr_ptr <= '0;
          end else if (wr_store) begin
            if (last_byte) begin
              wr_ptr      <= '0;
              state       <= DONE;
              frame_count <= frame_count + 8'd1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (wr_drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Out-of-range reads still occupy the read slot but leave the port idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (rd_req) begin
      mem_en <= rd_in_range;
      mem_we <= 1'b0;
      if (rd_in_range) begin
        mem_addr <= rd_addr;
      end
    end else if (wr_store) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wr_ptr;
      mem_wdata <= wr_data;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_stage1    <= 1'b0;
      rd_stage1_ok <= 1'b0;
      rd_valid     <= 1'b0;
      rd_stage2_ok <= 1'b0;
    end else begin
      rd_stage1    <= rd_req;
      rd_stage1_ok <= rd_req && rd_in_range;
      rd_valid     <= rd_stage1;
      rd_stage2_ok <= rd_stage1_ok;
    end
  end

  assign rd_data = rd_stage2_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter using a shrunken frame, a BSRAM model
// and a cycle-level reference model of the capture/read rules.
module tb_fb_port_arbiter;

  localparam int IMG = 200;
  localparam int AW  = 8;
  localparam int DW  = 8;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          frame_busy;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic [15:0]   drop_count;

  fb_port_arbiter #(.IMAGE_SIZE(IMG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BSRAM with one cycle of read latency
  logic [DW-1:0] bram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  typedef struct { int due; logic [7:0] data; } rd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic exp_en; logic [7:0] exp_data; } rd_vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  logic [7:0]    ref_mem [IMG];
  rd_exp_t       rq[$];
  bit            m_recv, m_done;
  int            m_ptr, m_fc, m_dc;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          seen_ready;
  bit            held;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_recv = 0; m_done = 0; m_ptr = 0; m_fc = 0; m_dc = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    rq.delete();
    held = 0;
  endtask

  // One clock: check outputs against the model, then advance the model
  task automatic applyStimulus();
    logic ready, exp_rv, nd;
    logic [7:0] exp_rd;
    @(negedge clk);
    exp_rv = 0; exp_rd = 0; nd = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv = 1; exp_rd = rq[0].data; void'(rq.pop_front());
    end
    ready = !rd_req && !frame_start && !m_done;
    seen_ready = wr_ready;
    checkOutput("wr_ready",    32'(wr_ready),    32'(ready));
    checkOutput("mem_en",      32'(mem_en),      32'(e_en));
    checkOutput("mem_we",      32'(mem_we),      32'(e_we));
    checkOutput("mem_addr",    32'(mem_addr),    32'(e_addr));
    checkOutput("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
    checkOutput("rd_valid",    32'(rd_valid),    32'(exp_rv));
    checkOutput("rd_data",     32'(rd_data),     32'(exp_rd));
    checkOutput("frame_busy",  32'(frame_busy),  32'(m_recv));
    checkOutput("frame_done",  32'(frame_done),  32'(m_done));
    checkOutput("frame_count", 32'(frame_count), 32'(m_fc));
    checkOutput("drop_count",  32'(drop_count),  32'(m_dc));
    held = wr_valid && !ready;
    e_en = 0; e_we = 0;
    if (rd_req) begin
      if (int'(rd_addr) < IMG) begin
        e_en = 1; e_addr = rd_addr;
        rq.push_back('{cyc + 2, ref_mem[int'(rd_addr)]});
      end else begin
        rq.push_back('{cyc + 2, 8'h00});
      end
    end
    if (wr_valid && ready) begin
      if (m_recv) begin
        e_en = 1; e_we = 1; e_addr = AW'(m_ptr); e_wdata = wr_data;
        ref_mem[m_ptr] = wr_data;
        if (m_ptr == IMG - 1) begin
          m_ptr = 0; m_recv = 0; nd = 1; m_fc = (m_fc + 1) % 256;
        end else begin
          m_ptr++;
        end
      end else if (m_dc < 65535) begin
        m_dc++;
      end
    end
    if (m_done) m_done = 0;
    else if (frame_start) begin m_recv = 1; m_ptr = 0; end
    if (nd) m_done = 1;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic pushBytes(input int n, input int first);
    wr_valid = 1;
    for (int i = 0; i < n; i++) begin
      wr_data = DW'(first + i);
      applyStimulus();
    end
    wr_valid = 0;
  endtask

  task automatic pulseFrameStart();
    frame_start = 1;
    applyStimulus();
    frame_start = 0;
  endtask

  initial begin
    rd_vec_t vecs[6];
    int lows, fc_before;

    vecs[0] = '{8'd0,   1'b1, 8'd0};
    vecs[1] = '{8'd1,   1'b1, 8'd1};
    vecs[2] = '{8'd100, 1'b1, 8'd100};
    vecs[3] = '{8'd199, 1'b1, 8'd199};
    vecs[4] = '{8'd200, 1'b0, 8'd0};
    vecs[5] = '{8'd255, 1'b0, 8'd0};

    for (int i = 0; i < IMG; i++) ref_mem[i] = 8'h00;
    rst_n = 0; frame_start = 0; wr_data = 0; wr_valid = 0; rd_req = 0; rd_addr = 0;
    modelReset();
    #23;
    checkOutput("reset_mem_en",      32'(mem_en),      32'd0);
    checkOutput("reset_rd_valid",    32'(rd_valid),    32'd0);
    checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
    checkOutput("reset_drop_count",  32'(drop_count),  32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // full frame, value = addr[7:0]
    pulseFrameStart();
    pushBytes(IMG, 0);
    checkOutput("fill_frame_done",  32'(frame_done),  32'd1);
    checkOutput("fill_frame_count", 32'(frame_count), 32'd1);
    applyStimulus();
    checkOutput("fill_back_idle", 32'(frame_busy | frame_done), 32'd0);

    // table-driven reads, including out-of-range addresses
    for (int v = 0; v < 6; v++) begin
      rd_req = 1; rd_addr = vecs[v].addr;
      applyStimulus();
      rd_req = 0;
      checkOutput("tbl_mem_en", 32'(mem_en), 32'(vecs[v].exp_en));
      applyStimulus();
      checkOutput("tbl_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("tbl_rd_data",  32'(rd_data),  32'(vecs[v].exp_data));
    end

    // bytes offered in IDLE are dropped without touching memory
    pushBytes(5, 0);
    checkOutput("idle_drop5", 32'(drop_count), 32'd5);

    // restart mid-frame
    pulseFrameStart();
    pushBytes(50, 7);
    fc_before = int'(frame_count);
    wr_valid = 1; frame_start = 1; wr_data = 8'hA5;
    applyStimulus();
    frame_start = 0;
    applyStimulus();
    checkOutput("restart_addr0", 32'(mem_addr), 32'd0);
    checkOutput("restart_fc",    32'(frame_count), 32'(fc_before));
    pushBytes(IMG - 2, 1);
    checkOutput("restart_not_done", 32'(frame_done), 32'd0);
    pushBytes(1, 9);
    checkOutput("restart_done", 32'(frame_done), 32'd1);
    checkOutput("restart_fc_inc", 32'(frame_count), 32'(fc_before + 1));
    applyStimulus();

    // 10-cycle read burst against a waiting writer
    pulseFrameStart();
    pushBytes(30, 0);
    lows = 0;
    wr_valid = 1; wr_data = 8'd30;
    for (int k = 0; k < 10; k++) begin
      rd_req = 1; rd_addr = AW'(k * 3);
      applyStimulus();
      if (!seen_ready) lows++;
    end
    rd_req = 0;
    applyStimulus();
    if (!seen_ready) lows++;
    checkOutput("burst_ready_lows", 32'(lows), 32'd10);
    checkOutput("burst_next_addr",  32'(mem_addr), 32'd30);
    checkOutput("burst_next_we",    32'(mem_we),   32'd1);
    pushBytes(IMG - 31, 31);
    applyStimulus();

    // randomized traffic honoring the valid/ready hold rule
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        wr_valid = ($urandom % 4) != 0;
        wr_data  = DW'($urandom);
      end
      rd_req      = ($urandom % 4) == 0;
      rd_addr     = AW'($urandom_range(0, 255));
      frame_start = (!m_recv && !m_done) ? (($urandom % 20) == 0) : (($urandom % 700) == 0);
      applyStimulus();
    end
    wr_valid = 0; rd_req = 0; frame_start = 0;
    applyStimulus(); applyStimulus(); applyStimulus();

    // reset mid-frame while a write is on the port and another byte is accepted
    pulseFrameStart();
    pushBytes(20, 0);
    wr_valid = 1;
    applyStimulus();
    checkOutput("prereset_mem_en", 32'(mem_en), 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("async_mem_en",     32'(mem_en),     32'd0);
    checkOutput("async_mem_we",     32'(mem_we),     32'd0);
    checkOutput("async_frame_busy", 32'(frame_busy), 32'd0);
    wr_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    modelReset();
    @(posedge clk); #1;
    checkOutput("post_wr_ready",    32'(wr_ready),    32'd1);
    checkOutput("post_frame_count", 32'(frame_count), 32'd0);
    checkOutput("post_drop_count",  32'(drop_count),  32'd0);
    checkOutput("post_busy",        32'(frame_busy),  32'd0);
    applyStimulus();

    // drop counter saturation
    pushBytes(65540, 0);
    checkOutput("drop_saturate", 32'(drop_count), 32'd65535);
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
